// File: rtl/uart_pkg.sv
// Shared types and elaboration-time helpers for the FIFO-fed UART transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    function automatic int baud_cnt_w(input int clks_per_bit);
        return (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
    endfunction

    function automatic int frame_len(input int clks_per_bit, input int width,
                                     input int parity_en, input int stop_bits);
        return clks_per_bit * (1 + width + parity_en + stop_bits);
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module uart_baud_cnt
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic bit_tick
);

    localparam int CW = baud_cnt_w(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr || cnt_q == LAST) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_tick = (cnt_q == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from a registered-read FIFO and serialises them as UART frames
// (start, LSB-first data, optional even parity, 1 or 2 stop bits).
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             fifo_rd_en,
    output logic             tx,
    output logic             busy,
    output logic             tx_done
);

    localparam int BW = $clog2(WIDTH) + 1;
    localparam logic [BW-1:0] LAST_DATA = BW'(WIDTH - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             parity_q, parity_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic             tx_q, tx_d;
    logic             bit_tick;
    logic             pop;
    logic             baud_clr;

    // Reset gating keeps the pop strobe quiet while the block is held in reset,
    // even though the state register already reads IDLE.
    assign pop        = rst_n && (state_q == ST_IDLE) && enable && !fifo_empty;
    assign fifo_rd_en = pop;
    assign baud_clr   = (state_d != state_q) || (state_q == ST_IDLE);

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (baud_clr),
        .bit_tick(bit_tick)
    );

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        bit_d    = bit_q;
        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                shift_d  = fifo_data;
                parity_d = ^fifo_data;
                state_d  = ST_START;
            end
            ST_START: begin
                if (bit_tick) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == LAST_DATA) begin
                        bit_d   = '0;
                        state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (bit_tick) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_tick) begin
                    if (bit_q == LAST_STOP) begin
                        bit_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Line level is derived from the next state so the registered tx lines up with state_q.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
            ST_PARITY: tx_d = parity_d;
            default:   tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            shift_q  <= '0;
            parity_q <= 1'b0;
            bit_q    <= '0;
            tx_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            bit_q    <= bit_d;
            tx_q     <= tx_d;
        end
    end

    assign tx      = tx_q;
    assign busy    = (state_q != ST_IDLE);
    assign tx_done = (state_q == ST_STOP) && bit_tick && (bit_q == LAST_STOP);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench: instance A is 8N1, instance B is 8E1; each fed by a small registered-read FIFO model.
module tb_fifo_uart_tx;

    localparam int CPB = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       en_a = 1'b0, en_b = 1'b0;
    logic       empty_a, empty_b;
    logic [7:0] data_a = '0, data_b = '0;
    logic       rd_a, rd_b, tx_a, tx_b, busy_a, busy_b, done_a, done_b;

    logic [7:0] mem_a [256];
    logic [7:0] mem_b [256];
    int push_a = 0, push_b = 0, pop_a = 0, pop_b = 0;
    int rdcnt_a = 0, rdcnt_b = 0, donecnt_a = 0, donecnt_b = 0, bad_pop = 0;
    int checks = 0, errors = 0;

    assign empty_a = (push_a == pop_a);
    assign empty_b = (push_b == pop_b);

    fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .enable(en_a), .fifo_empty(empty_a), .fifo_data(data_a),
        .fifo_rd_en(rd_a), .tx(tx_a), .busy(busy_a), .tx_done(done_a));

    fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .STOP_BITS(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .enable(en_b), .fifo_empty(empty_b), .fifo_data(data_b),
        .fifo_rd_en(rd_b), .tx(tx_b), .busy(busy_b), .tx_done(done_b));

    // FIFO models: data_out is registered, valid the cycle after rd_en is sampled.
    always @(posedge clk) begin
        if (rd_a && !empty_a) begin
            data_a <= mem_a[pop_a[7:0]];
            pop_a  <= pop_a + 1;
        end
        if (rd_b && !empty_b) begin
            data_b <= mem_b[pop_b[7:0]];
            pop_b  <= pop_b + 1;
        end
        if (rd_a) rdcnt_a <= rdcnt_a + 1;
        if (rd_b) rdcnt_b <= rdcnt_b + 1;
        if (done_a) donecnt_a <= donecnt_a + 1;
        if (done_b) donecnt_b <= donecnt_b + 1;
        if ((rd_a && empty_a) || (rd_b && empty_b)) bad_pop <= bad_pop + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int inst, input logic [7:0] d);
        if (inst == 0) begin
            mem_a[push_a[7:0]] = d;
            push_a++;
        end else begin
            mem_b[push_b[7:0]] = d;
            push_b++;
        end
    endtask

    // Reference line level at cycle cyc of a frame, from the frame-format rules.
    function automatic logic exp_tx(input logic [7:0] d, input int par, input int cyc);
        int k;
        k = cyc / CPB;
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
        if (par != 0 && k == 9) return ^d;
        return 1'b1;
    endfunction

    task automatic wait_start(input int inst, output int gap, output bit ok);
        gap = 0;
        ok  = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (((inst == 0) ? tx_a : tx_b) == 1'b0) begin
                ok = 1'b1;
                return;
            end
            gap++;
        end
        checks++;
        errors++;
        $display("FAIL start_timeout inst %0d: got no start bit within 200 cycles", inst);
    endtask

    task automatic check_frame(input int inst, input logic [7:0] d, input bit drop_en,
                               output int gap, output int got_len, output int got_par);
        bit   ok;
        int   par;
        int   len;
        logic t, dn, bz;
        par     = inst;
        len     = CPB * (1 + 8 + par + 1);
        got_len = 0;
        got_par = -1;
        wait_start(inst, gap, ok);
        if (!ok) return;
        for (int c = 0; c < len; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 1 && drop_en) en_a = 1'b0;
            t  = (inst == 0) ? tx_a : tx_b;
            dn = (inst == 0) ? done_a : done_b;
            bz = (inst == 0) ? busy_a : busy_b;
            chk($sformatf("tx i%0d b%02h c%0d", inst, d, c), int'(t), int'(exp_tx(d, par, c)));
            chk($sformatf("done i%0d b%02h c%0d", inst, d, c), int'(dn), (c == len - 1) ? 1 : 0);
            chk($sformatf("busy i%0d b%02h c%0d", inst, d, c), int'(bz), 1);
            if (dn && got_len == 0) got_len = c + 1;
            if (par != 0 && c == 9 * CPB + CPB / 2) got_par = int'(t);
        end
    endtask

    typedef struct {
        int         inst;
        logic [7:0] d;
        int         exp_len;
        int         exp_par;
    } vec_t;

    initial begin
        vec_t tbl[6];
        int gap, glen, gpar, r0, d0, bad;
        int inst;
        logic [7:0] d;

        tbl[0] = '{0, 8'hA5, 40, -1};
        tbl[1] = '{1, 8'h07, 44, 1};
        tbl[2] = '{1, 8'h03, 44, 0};
        tbl[3] = '{0, 8'h00, 40, -1};
        tbl[4] = '{0, 8'hFF, 40, -1};
        tbl[5] = '{1, 8'h5A, 44, 0};

        en_a = 1'b1;
        en_b = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset tx_a", int'(tx_a), 1);
        chk("reset tx_b", int'(tx_b), 1);
        chk("reset busy", int'(busy_a | busy_b), 0);
        chk("reset done", int'(done_a | done_b), 0);
        chk("reset rd_en", int'(rd_a | rd_b), 0);
        rst_n = 1'b1;

        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (rd_a || rd_b || !tx_a || !tx_b || busy_a || busy_b) bad++;
        end
        chk("empty idle violations", bad, 0);

        for (int i = 0; i < 6; i++) begin
            r0 = (tbl[i].inst == 0) ? rdcnt_a : rdcnt_b;
            push(tbl[i].inst, tbl[i].d);
            check_frame(tbl[i].inst, tbl[i].d, 1'b0, gap, glen, gpar);
            chk($sformatf("tbl%0d frame length", i), glen, tbl[i].exp_len);
            chk($sformatf("tbl%0d parity bit", i), gpar, tbl[i].exp_par);
            @(negedge clk);
            chk($sformatf("tbl%0d busy after", i), int'((tbl[i].inst == 0) ? busy_a : busy_b), 0);
            chk($sformatf("tbl%0d rd pulses", i), ((tbl[i].inst == 0) ? rdcnt_a : rdcnt_b) - r0, 1);
        end

        for (int i = 0; i < 16; i++) begin
            inst = int'($urandom_range(0, 1));
            d    = 8'($urandom_range(0, 255));
            push(inst, d);
            check_frame(inst, d, 1'b0, gap, glen, gpar);
            chk($sformatf("rand%0d frame length", i), glen, CPB * (10 + inst));
        end

        // Back-to-back frames
        repeat (3) @(negedge clk);
        r0 = rdcnt_a;
        d0 = donecnt_a;
        push(0, 8'h01);
        push(0, 8'hFF);
        check_frame(0, 8'h01, 1'b0, gap, glen, gpar);
        check_frame(0, 8'hFF, 1'b0, gap, glen, gpar);
        chk("b2b idle gap", gap, 2);
        @(negedge clk);
        chk("b2b rd pulses", rdcnt_a - r0, 2);
        chk("b2b done pulses", donecnt_a - d0, 2);

        // Reset during data bit 3 of 0x34 (bit 3 = 0, so tx is low before reset)
        push(0, 8'h34);
        push(0, 8'h96);
        wait_start(0, gap, glen[0]);
        repeat (4 * CPB + 1) @(negedge clk);
        chk("pre-reset tx low", int'(tx_a), 0);
        d0 = donecnt_a;
        #1 rst_n = 1'b0;
        #1;
        chk("async reset tx", int'(tx_a), 1);
        chk("async reset busy", int'(busy_a), 0);
        chk("reset rd_en gated", int'(rd_a), 0);
        repeat (3) @(negedge clk);
        chk("reset no done", donecnt_a - d0, 0);
        chk("reset no pop", pop_a, push_a - 1);
        rst_n = 1'b1;
        check_frame(0, 8'h96, 1'b0, gap, glen, gpar);
        chk("post-reset frame length", glen, 40);

        // Enable dropped during START
        repeat (3) @(negedge clk);
        r0 = rdcnt_a;
        push(0, 8'h55);
        push(0, 8'h66);
        check_frame(0, 8'h55, 1'b1, gap, glen, gpar);
        chk("en-drop frame length", glen, 40);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (rd_a || !tx_a || busy_a) bad++;
        end
        chk("en-drop idle violations", bad, 0);
        chk("en-drop rd pulses", rdcnt_a - r0, 1);
        en_a = 1'b1;
        check_frame(0, 8'h66, 1'b0, gap, glen, gpar);
        chk("en-restore rd pulses", rdcnt_a - r0, 2);

        chk("pop while empty", bad_pop, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Downstream consumer of the team's synchronous FIFO: pops one byte at a time and serialises it onto a UART TX line.
- Frame format: 8N1 by default, with optional even parity and 2 stop bits.
- Accounts for the FIFO's one-cycle registered read latency: data_out is valid the cycle after rd_en is sampled.
- Sits between the TX FIFO and the chip pad / UART PHY.

Parameters:
- WIDTH, 8, data bits per frame; must match the FIFO width.
- CLKS_PER_BIT, 16, clk cycles per UART bit; minimum 2.
- PARITY_EN, 0, 1 = append one even-parity bit after the data bits.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clk  input  1  system clock, all logic on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  allows a new frame to start; does not abort a frame in progress.
- fifo_empty  input  1  empty flag from the FIFO.
- fifo_data  input  WIDTH  FIFO data_out; valid the cycle after fifo_rd_en.
- fifo_rd_en  output  1  FIFO pop strobe.
- tx  output  1  serial line, idle high; registered.
- busy  output  1  high whenever state is not IDLE.
- tx_done  output  1  one-cycle pulse on the final cycle of the last stop bit.

Behaviour:
- Reset (async, rst_n=0): tx=1, busy=0, tx_done=0, fifo_rd_en=0, state=IDLE, all counters=0. Applies immediately, including mid-frame. The in-flight byte is lost; the FIFO is not rewound.
- States: IDLE, FETCH, START, DATA, PARITY, STOP.
- IDLE:
  - fifo_rd_en = enable & ~fifo_empty (combinational, IDLE only).
  - If that term is 1, go to FETCH on the next edge.
  - tx=1.
- FETCH (1 cycle):
  - fifo_data is now valid; latch it into the shift register.
  - Compute parity = XOR of the data bits; go to START.
  - tx=1.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA:
  - tx = shift_reg[0], LSB first; each bit lasts CLKS_PER_BIT cycles.
  - Shift right at each bit boundary.
  - After WIDTH bits, go to PARITY if PARITY_EN, else STOP.
- PARITY: tx = parity bit, for CLKS_PER_BIT cycles.
- STOP:
  - tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - tx_done=1 on the final cycle, then go to IDLE.
- Baud counter:
  - Width $clog2(CLKS_PER_BIT).
  - Counts 0..CLKS_PER_BIT-1 and wraps; the bit boundary is at count == CLKS_PER_BIT-1.
  - Cleared on every state change.
- Bit counter: width $clog2(WIDTH)+1; counts data bits sent.
- Frame length (cycles, START through STOP) = CLKS_PER_BIT*(1+WIDTH+PARITY_EN+STOP_BITS).
- Back-to-back frames: STOP always returns to IDLE. The inter-frame gap is exactly 2 idle-high cycles (IDLE + FETCH) when the FIFO is non-empty and enable=1.
- fifo_rd_en is never asserted while fifo_empty=1, and at most once per frame.
- enable deasserted mid-frame: the current frame completes normally; no further pop.
- fifo_empty rising during a frame has no effect; the byte is already latched.
- tx is glitch-free (driven from a register); busy is derived from state.

Decomposition:
- Package uart_pkg:
  - state enum (IDLE, FETCH, START, DATA, PARITY, STOP).
  - localparam functions for the baud counter width and the frame length.
- One natural sub-module, uart_baud_cnt:
  - Parameter CLKS_PER_BIT; inputs clk, rst_n, clr.
  - Output bit_tick: a pulse on the last cycle of each bit.
- The FSM, shift register and parity live in the top module.

Test Plan:
- CLKS_PER_BIT=4, default params, FIFO preloaded with 0xA5, enable=1:
  - one fifo_rd_en pulse.
  - tx for 4 cycles each: 0,1,0,1,0,0,1,0,1,1.
  - 40-cycle frame, tx_done on cycle 40, busy low afterwards.
- PARITY_EN=1, byte 0x07: parity bit = 1 after the data bits, frame = 44 cycles.
- PARITY_EN=1, byte 0x03: parity bit = 0.
- Back-to-back, bytes 0x01 then 0xFF:
  - two tx_done pulses.
  - exactly 2 idle-high cycles between the first STOP and the second START.
  - two fifo_rd_en pulses total.
- fifo_empty=1 and enable=1 held for 100 cycles: fifo_rd_en stays 0, tx=1, busy=0.
- Reset mid-frame: drop rst_n during DATA bit 3.
  - tx=1 asynchronously, no tx_done.
  - After release with the FIFO non-empty, the next frame starts cleanly with the next byte.
- enable dropped during START of 0x55: that frame completes, with no further fifo_rd_en while enable=0.
